imem_loader: RTL and testbench

//  Write-side partner of the instruction memory. The CPU core only ever reads instr_mem.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_word_assembler.sv | 44 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The loader accepts a framed byte stream and writes the image into instr_mem.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int LEN_W          = 8 * LEN_BYTES;

    // A frame is only accepted when it carries at least one word and cannot overrun memory.
    function automatic logic len_ok(input logic [LEN_W-1:0] n, input int max_words);
        return (n != '0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects little-endian bytes into one instruction word.
// Flags the byte that completes a word and presents the completed value on o_word.
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_next;

    // o_word already includes the byte being accepted, so the final byte lands in the write.
    always_comb begin
        w_word_next = r_word;
        w_word_next[8*r_byte_idx +: 8] = i_byte;
    end

    assign o_word       = w_word_next;
    assign o_word_ready = i_load && (r_byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_idx <= '0;
            r_word     <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
        end else if (i_load) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Write-side loader for instr_mem: parses the frame, writes the assembled words and verifies the XOR checksum.
// It keeps the CPU in reset until a complete, verified image has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                  MAX_WORDS   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [PC_WIDTH-1:0]    imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int WIDX_W = $clog2(MAX_WORDS + 1);

    loader_state_t          r_state;
    logic [7:0]             r_len_lo;
    logic [WIDX_W-1:0]      r_len;
    logic [WIDX_W-1:0]      r_word_idx;
    logic [7:0]             r_csum;
    logic                   r_we;
    logic [PC_WIDTH-1:0]    r_addr;
    logic [INSTR_WIDTH-1:0] r_wdata;
    logic                   r_cpu_rst;
    logic                   r_done;
    logic                   r_err;

    logic                   w_rx_ready;
    logic                   w_hs;
    logic                   w_start_ok;
    logic                   w_load;
    logic [LEN_W-1:0]       w_len;
    logic [INSTR_WIDTH-1:0] w_word;
    logic                   w_word_ready;
    logic                   w_last_word;

    assign w_rx_ready  = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                         (r_state == ST_DATA)   || (r_state == ST_CSUM);
    assign w_hs        = rx_valid && w_rx_ready;
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_load      = w_hs && (r_state == ST_DATA);
    assign w_len       = {rx_data, r_len_lo};
    assign w_last_word = (r_word_idx == r_len - 1'b1);

    word_assembler #(
        .WORD_W (INSTR_WIDTH)
    ) u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_load       (w_load),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_csum     <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // Write port is registered: strobe, address and data appear the cycle after byte 3.
            if (w_word_ready) begin
                r_we       <= 1'b1;
                r_addr     <= BASE_ADDR + PC_WIDTH'(r_word_idx) * PC_WIDTH'(BYTES_PER_WORD);
                r_wdata    <= w_word;
                r_word_idx <= r_word_idx + 1'b1;
            end
            if (w_load) begin
                r_csum <= r_csum ^ rx_data;
            end

            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state    <= ST_LEN_LO;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_word_idx <= '0;
                        r_csum     <= '0;
                        r_cpu_rst  <= 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    if (w_hs) begin
                        r_len_lo <= rx_data;
                        r_state  <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_hs) begin
                        if (len_ok(w_len, MAX_WORDS)) begin
                            r_len   <= WIDX_W'(w_len);
                            r_state <= ST_DATA;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_ready && w_last_word) begin
                        r_state <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (w_hs) begin
                        if (rx_data == r_csum) begin
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                            r_state   <= ST_DONE;
                        end else begin
                            r_err     <= 1'b1;
                            r_state   <= ST_ERR;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_ready   = w_rx_ready;
    assign busy       = w_rx_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame loading, checksum errors, length limits and mid-frame reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          t0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("handshake_timeout", {31'b0, rx_ready}, 32'd1);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wa.delete();
        wd.delete();
    endtask

    task automatic send_frame1(input logic [7:0] csum);
        send(8'h01, 0); send(8'h00, 0);
        send(8'h13, 0); send(8'h05, 0); send(8'hA0, 0); send(8'h00, 0);
        send(csum, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_cpu_rst",  {31'b0, cpu_rst},  32'd1);
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_imem_we",  {31'b0, imem_we},  32'd0);
        check("rst_done",     {31'b0, done},     32'd0);
        check("rst_err",      {31'b0, err},      32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        pulse_start();
        check("start_rx_ready", {31'b0, rx_ready}, 32'd1);
        check("start_busy",     {31'b0, busy},     32'd1);
        check("start_cpu_rst",  {31'b0, cpu_rst},  32'd1);

        // Single-word frame
        clear_writes();
        send_frame1(8'hB6);
        check("t2_nwrites", wa.size(), 32'd1);
        check("t2_addr",    wa[0],     32'h0000_0000);
        check("t2_wdata",   wd[0],     32'h00A0_0513);
        check("t2_done",    {31'b0, done},    32'd1);
        check("t2_cpu_rst", {31'b0, cpu_rst}, 32'd0);
        check("t2_err",     {31'b0, err},     32'd0);
        rx_valid = 1'b1; rx_data = 8'h55;
        repeat (2) @(negedge clk);
        check("t2_done_ready", {31'b0, rx_ready}, 32'd0);
        check("t2_done_hold",  {31'b0, done},     32'd1);
        rx_valid = 1'b0;

        // Two words with random gaps
        pulse_start();
        check("t3_restart_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check("t3_restart_done",    {31'b0, done},    32'd0);
        clear_writes();
        send(8'h02, $urandom_range(0, 3)); send(8'h00, $urandom_range(0, 3));
        send(8'h11, $urandom_range(0, 3)); send(8'h22, $urandom_range(0, 3));
        send(8'h33, $urandom_range(0, 3)); send(8'h44, $urandom_range(0, 3));
        send(8'hAA, $urandom_range(0, 3)); send(8'hBB, $urandom_range(0, 3));
        send(8'hCC, $urandom_range(0, 3)); send(8'hDD, $urandom_range(0, 3));
        send(8'h44, $urandom_range(0, 3));
        check("t3_nwrites", wa.size(), 32'd2);
        check("t3_addr0",   wa[0], 32'h0000_0000);
        check("t3_wdata0",  wd[0], 32'h4433_2211);
        check("t3_addr1",   wa[1], 32'h0000_0004);
        check("t3_wdata1",  wd[1], 32'hDDCC_BBAA);
        check("t3_done",    {31'b0, done}, 32'd1);

        // Same frame back-to-back: 11 bytes in 11 cycles
        pulse_start();
        clear_writes();
        t0 = cyc;
        send(8'h02, 0); send(8'h00, 0);
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
        send(8'h44, 0);
        check("t3_cycles",   cyc - t0,  32'd11);
        check("t3b_nwrites", wa.size(), 32'd2);
        check("t3b_wdata1",  wd[1],     32'hDDCC_BBAA);
        check("t3b_done",    {31'b0, done}, 32'd1);

        // Bad checksum, then recovery
        pulse_start();
        send_frame1(8'hB7);
        check("t4_err",     {31'b0, err},     32'd1);
        check("t4_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        check("t4_done",    {31'b0, done},    32'd0);
        check("t4_ready",   {31'b0, rx_ready}, 32'd0);
        pulse_start();
        check("t4_err_clr", {31'b0, err}, 32'd0);
        send_frame1(8'hB6);
        check("t4_done2",    {31'b0, done},    32'd1);
        check("t4_cpu_rst2", {31'b0, cpu_rst}, 32'd0);

        // Illegal lengths
        pulse_start();
        clear_writes();
        send(8'h00, 0); send(8'h00, 0);
        check("t5_zero_err",  {31'b0, err},  32'd1);
        check("t5_zero_busy", {31'b0, busy}, 32'd0);
        pulse_start();
        send(8'h01, 0); send(8'h01, 0);
        check("t5_257_err",     {31'b0, err},     32'd1);
        check("t5_257_cpu_rst", {31'b0, cpu_rst}, 32'd1);
        repeat (2) @(negedge clk);
        check("t5_nwrites", wa.size(), 32'd0);

        // Reset in the middle of a word
        pulse_start();
        clear_writes();
        send(8'h01, 0); send(8'h00, 0); send(8'h13, 0); send(8'h05, 0);
        rx_valid = 1'b1; rx_data = 8'hA0;
        #2 rst = 1'b0;
        #1;
        check("t6_cpu_rst",  {31'b0, cpu_rst},  32'd1);
        check("t6_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("t6_busy",     {31'b0, busy},     32'd0);
        check("t6_imem_we",  {31'b0, imem_we},  32'd0);
        check("t6_addr",     imem_addr,         32'h0);
        check("t6_wdata",    imem_wdata,        32'h0);
        rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t6_start_in_rst", {31'b0, busy}, 32'd0);
        check("t6_nwrites", wa.size(), 32'd0);
        pulse_start();
        send_frame1(8'hB6);
        check("t6_reload_nwrites", wa.size(), 32'd1);
        check("t6_reload_wdata",   wd[0],     32'h00A0_0513);
        check("t6_reload_done",    {31'b0, done},    32'd1);
        check("t6_reload_cpu_rst", {31'b0, cpu_rst}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
